// File: rtl/hawk_tbl_wr_mngr.sv
// HAWK table write manager: merges one ATT/TOL entry into its cacheline and
// writes the line back with a single-beat AXI4 write, then reports done/error.
module hawk_tbl_wr_mngr #(
  parameter int                    AXI_ADDR_W = 64,
  parameter int                    AXI_DATA_W = 512,
  parameter int                    AXI_ID_W   = 4,
  parameter logic [AXI_ID_W-1:0]   WR_ID      = 4'h1,
  parameter logic [AXI_ADDR_W-1:0] ATT_START  = 64'h8000_0000,
  parameter logic [AXI_ADDR_W-1:0] LIST_START = 64'h8010_0000,
  parameter int                    IDX_W      = 20
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_type_i,
  input  logic [IDX_W-1:0]        req_entry_id_i,
  input  logic [127:0]            req_entry_i,
  input  logic [AXI_DATA_W-1:0]   req_line_i,
  output logic                    done_o,
  output logic                    err_o,
  output logic [31:0]             wr_cnt_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [AXI_ADDR_W-1:0]   awaddr_o,
  output logic [AXI_ID_W-1:0]     awid_o,
  output logic [7:0]              awlen_o,
  output logic [2:0]              awsize_o,
  output logic [1:0]              awburst_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  output logic [AXI_DATA_W-1:0]   wdata_o,
  output logic [AXI_DATA_W/8-1:0] wstrb_o,
  output logic                    wlast_o,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  input  logic [1:0]              bresp_i,
  input  logic [AXI_ID_W-1:0]     bid_i
);

  // state  | meaning
  // IDLE   | ready for an update request
  // SEND   | AW and W offered, each until its own handshake
  // WAIT_B | waiting for the write response
  // DONE   | one-cycle done/err report
  typedef enum logic [1:0] {IDLE, SEND, WAIT_B, DONE} state_t;

  state_t                  state, state_nxt;
  logic                    aw_done, w_done, err_flag;
  logic [31:0]             wr_cnt;
  logic [AXI_ADDR_W-1:0]   awaddr_q;
  logic [AXI_DATA_W-1:0]   wdata_q;
  logic [IDX_W-1:0]        n;
  logic [AXI_ADDR_W-1:0]   addr_calc;
  logic [AXI_DATA_W-1:0]   line_calc;
  logic                    accept, aw_fire, w_fire, b_fire, b_err;

  assign req_ready_o = (state == IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign awvalid_o   = (state == SEND) && !aw_done;
  assign wvalid_o    = (state == SEND) && !w_done;
  assign bready_o    = (state == WAIT_B);
  assign aw_fire     = awvalid_o && awready_i;
  assign w_fire      = wvalid_o && wready_i;
  assign b_fire      = bready_o && bvalid_i;
  assign b_err       = (bresp_i != 2'b00) || (bid_i != WR_ID);
  assign done_o      = (state == DONE);
  assign err_o       = (state == DONE) && err_flag;
  assign wr_cnt_o    = wr_cnt;
  assign awaddr_o    = awaddr_q;
  assign awid_o      = WR_ID;
  assign awlen_o     = 8'd0;
  assign awsize_o    = 3'b110;
  assign awburst_o   = 2'b01;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = '1;
  assign wlast_o     = wvalid_o;

  // ATT packs 8 x 64b entries per line, TOL packs 4 x 128b entries.
  always_comb begin
    n         = req_entry_id_i - IDX_W'(1);
    line_calc = req_line_i;
    if (!req_type_i) begin
      addr_calc = ATT_START + (AXI_ADDR_W'(n >> 3) << 6);
      line_calc[64*n[2:0] +: 64] = req_entry_i[63:0];
    end else begin
      addr_calc = LIST_START + (AXI_ADDR_W'(n >> 2) << 6);
      line_calc[128*n[1:0] +: 128] = req_entry_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept) state_nxt = (req_entry_id_i == '0) ? DONE : SEND;
      SEND:   if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = WAIT_B;
      WAIT_B: if (b_fire) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      err_flag <= 1'b0;
      wr_cnt   <= '0;
      awaddr_q <= '0;
      wdata_q  <= '0;
    end else begin
      if (accept) begin
        awaddr_q <= addr_calc;
        wdata_q  <= line_calc;
        err_flag <= (req_entry_id_i == '0);
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end
      if (state == SEND) begin
        aw_done <= aw_done || aw_fire;
        w_done  <= w_done || w_fire;
      end
      if (b_fire) begin
        if (b_err) err_flag <= 1'b1;
        else       wr_cnt   <= wr_cnt + 32'd1;
      end
    end
  end

endmodule
